// File: rtl/muon_decay_timer_if.sv
// Event-record handshake between the muon decay timer and the readout/DMA logic.
// The timer is the master (drives the record); the consumer drives evt_ready.
interface muon_decay_timer_if #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 16
);
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             evt_valid;
    logic             evt_ready;
    logic [WIDTH-1:0] evt_delta;
    logic [CHW-1:0]   evt_start_ch;
    logic [CHW-1:0]   evt_stop_ch;

    modport master (
        output evt_valid,
        output evt_delta,
        output evt_start_ch,
        output evt_stop_ch,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_delta,
        input  evt_start_ch,
        input  evt_stop_ch,
        output evt_ready
    );
endinterface

// File: rtl/muon_decay_timer.sv
// Multi-channel double-pulse timer: deglitch, edge-detect, time start->stop, buffer one record.
// Optional MUON_STATS_EN adds saturating single/double event counters.
module muon_decay_timer #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] trig_in,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic [WIDTH-1:0]  window,
    input  logic [WIDTH-1:0]  veto,
    output logic              busy,
    output logic              double_trig,
    output logic [15:0]       drop_count,
`ifdef MUON_STATS_EN
    output logic [31:0]       single_count,
    output logic [31:0]       double_count,
`endif
    muon_decay_timer_if.master evt
);
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [0:0] {IDLE, ARMED} state_t;

    logic [NUM_CH-1:0] s1_reg, s2_reg, s3_reg;
    logic [NUM_CH-1:0] edge_vec;
    logic              hit;
    logic [CHW-1:0]    hit_ch;

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  counter_reg, counter_next;
    logic [WIDTH-1:0]  elapsed;
    logic [WIDTH-1:0]  win_reg, veto_reg;
    logic [CHW-1:0]    start_ch_reg;
    logic              latch, accept, expire;

    logic              evt_valid_reg;
    logic [WIDTH-1:0]  evt_delta_reg;
    logic [CHW-1:0]    evt_start_reg, evt_stop_reg;
    logic              double_trig_reg;
    logic [15:0]       drop_count_reg;
    logic              consume, load, drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_reg <= '0;
            s2_reg <= '0;
            s3_reg <= '0;
        end else begin
            s1_reg <= trig_in;
            s2_reg <= s1_reg;
            s3_reg <= s2_reg;
        end
    end

    // A rising edge needs two consecutive high samples, so single-cycle glitches vanish.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_edge
            assign edge_vec[gi] = s1_reg[gi] & s2_reg[gi] & ~s3_reg[gi] & ch_en[gi];
        end
    endgenerate

    always_comb begin
        hit    = 1'b0;
        hit_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (edge_vec[i]) begin
                hit    = 1'b1;
                hit_ch = CHW'(i);
            end
        end
    end

    // elapsed is the cycle count since the start edge as seen at the current clock edge.
    assign elapsed = counter_reg + WIDTH'(1);
    assign expire  = (state_reg == ARMED) && (elapsed >= win_reg);

    always_comb begin
        state_next   = state_reg;
        counter_next = counter_reg;
        latch        = 1'b0;
        accept       = 1'b0;
        case (state_reg)
            IDLE: begin
                counter_next = '0;
                if (hit) begin
                    latch      = 1'b1;
                    state_next = ARMED;
                end
            end
            ARMED: begin
                counter_next = elapsed;
                if (expire) begin
                    counter_next = '0;
                    if (hit) latch = 1'b1;
                    else     state_next = IDLE;
                end else if (hit && (elapsed > veto_reg)) begin
                    accept       = 1'b1;
                    counter_next = '0;
                    state_next   = IDLE;
                end
            end
            default: begin
                state_next   = IDLE;
                counter_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            counter_reg  <= '0;
            win_reg      <= '0;
            veto_reg     <= '0;
            start_ch_reg <= '0;
        end else begin
            state_reg   <= state_next;
            counter_reg <= counter_next;
            if (latch) begin
                win_reg      <= window;
                veto_reg     <= veto;
                start_ch_reg <= hit_ch;
            end
        end
    end

    // A record consumed this cycle frees the buffer for a double accepted in the same cycle.
    assign consume = evt_valid_reg & evt.evt_ready;
    assign load    = accept & (~evt_valid_reg | evt.evt_ready);
    assign drop    = accept & ~load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_valid_reg   <= 1'b0;
            evt_delta_reg   <= '0;
            evt_start_reg   <= '0;
            evt_stop_reg    <= '0;
            double_trig_reg <= 1'b0;
            drop_count_reg  <= '0;
        end else begin
            double_trig_reg <= accept;
            if (load) begin
                evt_valid_reg <= 1'b1;
                evt_delta_reg <= elapsed;
                evt_start_reg <= start_ch_reg;
                evt_stop_reg  <= hit_ch;
            end else if (consume) begin
                evt_valid_reg <= 1'b0;
            end
            if (drop && (drop_count_reg != 16'hFFFF))
                drop_count_reg <= drop_count_reg + 16'd1;
        end
    end

`ifdef MUON_STATS_EN
    logic [31:0] single_count_reg, double_count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            single_count_reg <= '0;
            double_count_reg <= '0;
        end else begin
            if (expire && (single_count_reg != 32'hFFFF_FFFF))
                single_count_reg <= single_count_reg + 32'd1;
            if (accept && (double_count_reg != 32'hFFFF_FFFF))
                double_count_reg <= double_count_reg + 32'd1;
        end
    end

    assign single_count = single_count_reg;
    assign double_count = double_count_reg;
`endif

    assign busy             = (state_reg == ARMED);
    assign double_trig      = double_trig_reg;
    assign drop_count       = drop_count_reg;
    assign evt.evt_valid    = evt_valid_reg;
    assign evt.evt_delta    = evt_delta_reg;
    assign evt.evt_start_ch = evt_start_reg;
    assign evt.evt_stop_ch  = evt_stop_reg;
endmodule

// File: tb/tb_muon_decay_timer.sv
// Scoreboard bench for muon_decay_timer: pulse-level reference model, directed
// scenarios followed by randomized pulses, window/veto, channel enables and backpressure.
module tb_muon_decay_timer;
    localparam int N = 6000;

    typedef struct packed {
        logic [15:0] delta;
        logic [1:0]  sc;
        logic [1:0]  tc;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  trig_in = '0;
    logic [3:0]  ch_en = '0;
    logic [15:0] window = '0;
    logic [15:0] veto = '0;
    logic        busy, double_trig;
    logic [15:0] drop_count;
`ifdef MUON_STATS_EN
    logic [31:0] single_count, double_count;
`endif

    muon_decay_timer_if #(.NUM_CH(4), .WIDTH(16)) eif ();

    muon_decay_timer #(.NUM_CH(4), .WIDTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .trig_in     (trig_in),
        .ch_en       (ch_en),
        .window      (window),
        .veto        (veto),
        .busy        (busy),
        .double_trig (double_trig),
        .drop_count  (drop_count),
`ifdef MUON_STATS_EN
        .single_count(single_count),
        .double_count(double_count),
`endif
        .evt         (eif)
    );

    always #5 clk = ~clk;

    // Stimulus schedule, indexed by the clock edge that samples it.
    logic [3:0]  trig_s [N];
    logic [3:0]  det_s  [N];
    logic [3:0]  en_s   [N];
    logic [15:0] win_s  [N];
    logic [15:0] veto_s [N];
    logic        rdy_s  [N];
    // Model state after each edge.
    logic        busy_e [N];
    logic        dtrig_e[N];
    logic        val_e  [N];
    logic [15:0] drop_e [N];
    logic        rec_v  [N];
    rec_t        rec_s  [N];

    rec_t exp_q[$];
    int   got_d[$], got_s[$], got_t[$], got_c[$];
    int   total = 0;
    int   bad = 0;
    int   n_single = 0;
    int   n_double = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // A pulse high for >=2 cycles starting at edge p is acted on at edge p+2.
    task automatic add_pulse(input int ch, input int p, input int len);
        for (int i = 0; i < len; i++)
            if (p + i < N) trig_s[p + i][ch] = 1'b1;
        if (len >= 2 && p + 2 < N) det_s[p + 2][ch] = 1'b1;
    endtask

    task automatic build_schedule();
        int w, v, e, r;
        for (int k = 0; k < N; k++) begin
            trig_s[k] = '0; det_s[k] = '0; rec_v[k] = 1'b0;
            en_s[k] = 4'hF; win_s[k] = 16'd100; veto_s[k] = 16'd10;
            rdy_s[k] = (k < 1200) || (k == 1700) || (k >= 2000);
        end
        add_pulse(0, 10, 4);   add_pulse(2, 47, 4);
        add_pulse(0, 300, 4);  add_pulse(1, 305, 3);  add_pulse(3, 360, 4);
        add_pulse(1, 600, 4);
        add_pulse(0, 900, 4);  add_pulse(2, 1000, 4); add_pulse(1, 1030, 4);
        add_pulse(0, 1300, 4); add_pulse(1, 1320, 4);
        add_pulse(2, 1400, 4); add_pulse(3, 1425, 4);
        add_pulse(0, 1500, 4); add_pulse(1, 1530, 4);
        add_pulse(3, 1800, 1);
        for (int c = 0; c < 4; c++) begin
            int p, len;
            p = 2000 + int'($urandom_range(0, 50));
            while (p < N - 400) begin
                len = int'($urandom_range(1, 5));
                add_pulse(c, p, len);
                p += len + int'($urandom_range(3, 150));
            end
        end
        for (int s = 2000; s < N - 400; s += 250) begin
            v = int'($urandom_range(0, 60));
            r = int'($urandom_range(0, 9));
            w = (r == 0) ? 0 : (r == 1) ? 1 : (r == 2) ? v : int'($urandom_range(20, 150));
            e = int'($urandom_range(0, 15));
            for (int k = s; k < s + 250 && k < N - 400; k++) begin
                win_s[k] = 16'(w); veto_s[k] = 16'(v); en_s[k] = 4'(e);
                if (k < N - 300) rdy_s[k] = ($urandom_range(0, 9) < 7) && ((s / 250) % 4 != 1);
            end
        end
    endtask

    // Reference: spec rules applied to the list of detected edges, one edge at a time.
    task automatic run_model();
        bit armed = 0, valid = 0, det, dbl, can_start;
        int st = 0, wl = 0, vl = 0, sc = 0, ch, el, drops = 0;
        for (int k = 0; k < N; k++) begin
            det = 0; ch = 0;
            for (int c = 3; c >= 0; c--)
                if (det_s[k][c] && en_s[k][c]) begin det = 1; ch = c; end
            dbl = 0;
            can_start = !armed;
            if (armed) begin
                el = k - st;
                if (el >= wl) begin
                    armed = 0; can_start = 1; n_single++;
                end else if (det && el > vl) begin
                    armed = 0; dbl = 1; n_double++;
                end
            end
            if (can_start && det) begin
                armed = 1; st = k; wl = int'(win_s[k]); vl = int'(veto_s[k]); sc = ch;
            end
            if (dbl) begin
                if (!valid || rdy_s[k]) begin
                    valid = 1; rec_v[k] = 1'b1;
                    rec_s[k] = '{delta: 16'(el), sc: 2'(sc), tc: 2'(ch)};
                end else begin
                    drops++;
                end
            end else if (valid && rdy_s[k]) begin
                valid = 0;
            end
            busy_e[k] = armed; dtrig_e[k] = dbl; val_e[k] = valid; drop_e[k] = 16'(drops);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_double_trig"}, 32'(double_trig), 0);
        check({tag, "_evt_valid"}, 32'(eif.evt_valid), 0);
        check({tag, "_evt_delta"}, 32'(eif.evt_delta), 0);
        check({tag, "_start_ch"}, 32'(eif.evt_start_ch), 0);
        check({tag, "_stop_ch"}, 32'(eif.evt_stop_ch), 0);
        check({tag, "_drop_count"}, 32'(drop_count), 0);
`ifdef MUON_STATS_EN
        check({tag, "_single_count"}, single_count, 0);
        check({tag, "_double_count"}, double_count, 0);
`endif
    endtask

    initial begin
        rec_t e;
        int   waited, quiet;
        eif.evt_ready = 1'b0;
        build_schedule();
        run_model();
        repeat (3) @(negedge clk);
        #1 check_reset_values("reset");
        @(negedge clk);
        rst = 1'b0;

        fork
            begin : driver
                for (int k = 0; k < N; k++) begin
                    @(negedge clk);
                    trig_in = trig_s[k]; window = win_s[k]; veto = veto_s[k];
                    ch_en = en_s[k]; eif.evt_ready = rdy_s[k];
                    if (rec_v[k]) exp_q.push_back(rec_s[k]);
                end
            end
            begin : monitor
                for (int j = 0; j < N; j++) begin
                    @(negedge clk);
                    #2;
                    if (j > 0) begin
                        check("busy", 32'(busy), 32'(busy_e[j-1]));
                        check("double_trig", 32'(double_trig), 32'(dtrig_e[j-1]));
                        check("evt_valid", 32'(eif.evt_valid), 32'(val_e[j-1]));
                        check("drop_count", 32'(drop_count), 32'(drop_e[j-1]));
                    end
                    if (j == 1700) begin
                        check("held_drop_count", 32'(drop_count), 2);
                        check("held_valid", 32'(eif.evt_valid), 1);
                    end
                    if (j == 1701) check("valid_falls", 32'(eif.evt_valid), 0);
                    if (eif.evt_valid && eif.evt_ready) begin
                        got_d.push_back(int'(eif.evt_delta));
                        got_s.push_back(int'(eif.evt_start_ch));
                        got_t.push_back(int'(eif.evt_stop_ch));
                        got_c.push_back(j);
                        if (exp_q.size() == 0) begin
                            check("unexpected_record", 1, 0);
                        end else begin
                            e = exp_q.pop_front();
                            check("evt_delta", 32'(eif.evt_delta), 32'(e.delta));
                            check("evt_start_ch", 32'(eif.evt_start_ch), 32'(e.sc));
                            check("evt_stop_ch", 32'(eif.evt_stop_ch), 32'(e.tc));
                        end
                    end
                end
            end
        join

        // Directed scenarios, against hand-derived constants.
        if (got_d.size() < 4) begin
            check("directed_record_count", 32'(got_d.size()), 4);
        end else begin
            check("dir0_delta", 32'(got_d[0]), 37);
            check("dir0_start", 32'(got_s[0]), 0);
            check("dir0_stop", 32'(got_t[0]), 2);
            check("dir1_veto_delta", 32'(got_d[1]), 60);
            check("dir1_stop", 32'(got_t[1]), 3);
            check("dir2_restart_delta", 32'(got_d[2]), 30);
            check("dir2_start", 32'(got_s[2]), 2);
            check("dir3_held_delta", 32'(got_d[3]), 20);
            check("dir3_held_stop", 32'(got_t[3]), 1);
            check("dir3_consume_cycle", 32'(got_c[3]), 1700);
        end
        check("records_left", 32'(exp_q.size()), 0);
`ifdef MUON_STATS_EN
        check("single_count", single_count, 32'(n_single));
        check("double_count", double_count, 32'(n_double));
`endif

        // Mid-event reset: start an event, reset at counter 50, expect nothing afterwards.
        @(negedge clk);
        window = 16'd100; veto = 16'd10; ch_en = 4'hF; eif.evt_ready = 1'b1;
        trig_in = 4'b0010;
        waited = 0;
        while (!busy && waited < 10) begin
            @(negedge clk);
            if (waited == 3) trig_in = '0;
            waited++;
        end
        trig_in = '0;
        check("rst_test_busy_rise", 32'(busy), 1);
        repeat (49) @(negedge clk);
        rst = 1'b1;
        #1 check_reset_values("midrst");
        @(negedge clk);
        rst = 1'b0;
        quiet = 0;
        repeat (150) begin
            @(negedge clk);
            if (busy || eif.evt_valid || double_trig) quiet++;
        end
        check("post_reset_quiet", 32'(quiet), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
